// File: rtl/seq_counter.sv
// Table-driven sequence counter, all state on the falling edge of clk.
// Optional runtime-writable table enabled by defining SEQ_TABLE_WR_EN.
module seq_counter #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 10,
    parameter int RECOVER_IDX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_val,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         count,
    output logic                     tc,
    output logic                     on_table
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int unsigned DEPTH_U  = DEPTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] REC_IDX  = AW'(RECOVER_IDX);

    typedef enum logic {
        ST_ON_TABLE,
        ST_OFF_TABLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nx;
    logic [AW-1:0]    w_idx_fwd;
    logic [AW-1:0]    w_idx_bwd;
    logic [AW-1:0]    w_match_idx;
    logic             w_match;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic             r_tc;
    logic             w_tc_nx;
    logic [WIDTH-1:0] w_table [DEPTH];

`ifdef SEQ_TABLE_WR_EN
    logic [WIDTH-1:0] r_table [DEPTH];
    logic             w_wr_ok;

    assign w_wr_ok = wr_en && (32'(wr_addr) < 32'(DEPTH));

    // Non-blocking update: steps and load matching on this edge see the old contents.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                r_table[i] <= WIDTH'(i);
            end
        end else if (w_wr_ok) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
            w_table[i] = r_table[i];
        end
    end
`else
    logic w_wr_unused;

    assign w_wr_unused = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
            w_table[i] = WIDTH'(i);
        end
    end
`endif

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned i = DEPTH_U; i > 0; i--) begin
            if (w_table[i-1] == load_val) begin
                w_match     = 1'b1;
                w_match_idx = AW'(i - 1);
            end
        end
    end

    assign w_idx_fwd = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_idx_bwd = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_count_nx = r_count;
        w_tc_nx    = 1'b0;
        if (load) begin
            w_count_nx = load_val;
            if (w_match) begin
                w_idx_nx   = w_match_idx;
                w_state_nx = ST_ON_TABLE;
            end else begin
                w_state_nx = ST_OFF_TABLE;
            end
        end else if (en) begin
            case (r_state)
                ST_ON_TABLE: begin
                    w_idx_nx   = dir ? w_idx_bwd : w_idx_fwd;
                    w_count_nx = w_table[w_idx_nx];
                    w_tc_nx    = dir ? (r_idx == '0) : (r_idx == LAST_IDX);
                end
                ST_OFF_TABLE: begin
                    w_idx_nx   = REC_IDX;
                    w_count_nx = w_table[REC_IDX];
                    w_state_nx = ST_ON_TABLE;
                end
                default: begin
                    w_state_nx = ST_ON_TABLE;
                end
            endcase
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ON_TABLE;
            r_idx   <= '0;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_count <= w_count_nx;
            r_tc    <= w_tc_nx;
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign on_table = (r_state == ST_ON_TABLE);

endmodule

// File: tb/tb_seq_counter.sv
// Scoreboard bench for seq_counter (WIDTH=4, DEPTH=10, RECOVER_IDX=3); write-port
// vectors run when SEQ_TABLE_WR_EN is defined, constant-table vectors otherwise.
module tb_seq_counter;

    logic       clk = 1'b1;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] count;
    logic       tc;
    logic       on_table;
    logic       kick = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       t;
        logic       o;
    } exp_t;

    exp_t exp_q[$];

    seq_counter #(.WIDTH(4), .DEPTH(10), .RECOVER_IDX(3)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .tc(tc), .on_table(on_table)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT updates on negedge; outputs are sampled on posedge or on a kick.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge kick);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (count !== e.cnt || tc !== e.t || on_table !== e.o) begin
                    bad++;
                    $display("FAIL %s: got count=%0d tc=%0b on_table=%0b, want count=%0d tc=%0b on_table=%0b",
                             e.name, count, tc, on_table, e.cnt, e.t, e.o);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] c, input logic t, input logic o);
        exp_t e;
        e.name = nm;
        e.cnt  = c;
        e.t    = t;
        e.o    = o;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic e, input logic d, input logic ld, input logic [3:0] lv,
                        input logic we, input logic [3:0] wa, input logic [3:0] wd,
                        input logic [3:0] ec, input logic et, input logic eo, input string nm);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        en       = e;
        dir      = d;
        load     = ld;
        load_val = lv;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        push(nm, ec, et, eo);
    endtask

    task automatic adv(input logic d, input logic [3:0] ec, input logic et, input string nm);
        step(1'b1, d, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, ec, et, 1'b1, nm);
    endtask

    task automatic ldv(input logic [3:0] lv, input logic [3:0] ec, input logic eo, input string nm);
        step(1'b0, 1'b0, 1'b1, lv, 1'b0, 4'd0, 4'd0, ec, 1'b0, eo, nm);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [3:0] wd, input logic [3:0] ec, input string nm);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, wa, wd, ec, 1'b0, 1'b1, nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        wr_en = 1'b0;
        push("reset", 4'd0, 1'b0, 1'b1);
    endtask

    // Reset pulse strictly between falling edges, checked while it is still high.
    task automatic async_reset_pulse();
        @(posedge clk);
        #1;
        en    = 1'b0;
        load  = 1'b0;
        wr_en = 1'b0;
        #1;
        reset = 1'b1;
        push("async_reset", 4'd0, 1'b0, 1'b1);
        #1;
        kick = 1'b1;
        #1;
        kick  = 1'b0;
        reset = 1'b0;
    endtask

    int     fwd_vals[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
`ifdef SEQ_TABLE_WR_EN
    logic [3:0] prog_tbl[10] = '{4'd3, 4'd0, 4'd1, 4'd5, 4'd2, 4'd7, 4'd6, 4'd4, 4'd9, 4'd12};
`endif

    initial begin
        // reset state and full forward wrap over the identity table
        @(posedge clk);
        #1;
        push("reset_state", 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            adv(1'b0, 4'(fwd_vals[k]), (k == 9), "fwd_identity");
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "hold_tc_clear");

`ifdef SEQ_TABLE_WR_EN
        for (int k = 0; k < 10; k++) begin
            wr(4'(k), prog_tbl[k], 4'd0, "prog_write");
        end
        wr(4'd12, 4'd15, 4'd0, "write_out_of_range");
        ldv(4'd6, 4'd6, 1'b1, "load_6");
        adv(1'b0, 4'd4, 1'b0, "prog_fwd");
        adv(1'b0, 4'd9, 1'b0, "prog_fwd");
        adv(1'b0, 4'd12, 1'b0, "prog_fwd");
        adv(1'b0, 4'd3, 1'b1, "prog_wrap");
        ldv(4'd15, 4'd15, 1'b0, "load_off_table");
        adv(1'b1, 4'd5, 1'b0, "recover_dir_ignored");
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b1, "load_beats_en");
        adv(1'b1, 4'd2, 1'b0, "bwd_idx4");
        adv(1'b1, 4'd5, 1'b0, "bwd_idx3");
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 4'd11, 4'd1, 1'b0, 1'b1, "step_sees_old_entry");
        adv(1'b1, 4'd0, 1'b0, "bwd_idx1");
        adv(1'b0, 4'd11, 1'b0, "revisit_new_entry");
        wr(4'd2, 4'd13, 4'd11, "write_shown_entry");
        adv(1'b1, 4'd0, 1'b0, "bwd_idx1_again");
        adv(1'b0, 4'd13, 1'b0, "revisit_shown_entry");
        step(1'b0, 1'b0, 1'b1, 4'd14, 1'b1, 4'd8, 4'd14, 4'd14, 1'b0, 1'b0, "load_match_old_table");
        ldv(4'd14, 4'd14, 1'b1, "load_match_new_table");
        adv(1'b0, 4'd12, 1'b0, "fwd_idx9");
        adv(1'b0, 4'd3, 1'b1, "fwd_wrap_again");
        wr(4'd1, 4'd5, 4'd3, "write_duplicate");
        ldv(4'd5, 4'd5, 1'b1, "load_lowest_dup");
        adv(1'b0, 4'd13, 1'b0, "dup_step_by_index");
        adv(1'b1, 4'd5, 1'b0, "bwd_to_idx1");
        adv(1'b1, 4'd3, 1'b0, "bwd_to_idx0");
        adv(1'b1, 4'd12, 1'b1, "bwd_wrap_prog");
`else
        ldv(4'd6, 4'd6, 1'b1, "load_6");
        adv(1'b0, 4'd7, 1'b0, "const_fwd");
        adv(1'b0, 4'd8, 1'b0, "const_fwd");
        adv(1'b0, 4'd9, 1'b0, "const_fwd");
        adv(1'b0, 4'd0, 1'b1, "const_wrap");
        ldv(4'd15, 4'd15, 1'b0, "load_off_table");
        adv(1'b1, 4'd3, 1'b0, "recover_dir_ignored");
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b1, "load_beats_en");
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 4'd11, 4'd8, 1'b0, 1'b1, "write_ignored_step");
        adv(1'b1, 4'd7, 1'b0, "bwd_idx7");
        adv(1'b0, 4'd8, 1'b0, "revisit_idx8");
`endif

        // full reset, backward wrap, async reset mid-run, identity table afterwards
        do_reset();
        adv(1'b1, 4'd9, 1'b1, "bwd_wrap_after_reset");
        adv(1'b1, 4'd8, 1'b0, "bwd_after_wrap");
        adv(1'b0, 4'd9, 1'b0, "fwd_to_9");
        adv(1'b0, 4'd0, 1'b1, "fwd_wrap_tc");
        async_reset_pulse();
        adv(1'b0, 4'd1, 1'b0, "identity_after_reset");
        adv(1'b0, 4'd2, 1'b0, "identity_after_reset");
        adv(1'b0, 4'd3, 1'b0, "identity_after_reset");
        ldv(4'd7, 4'd7, 1'b1, "load_identity_7");
        adv(1'b0, 4'd8, 1'b0, "fwd_from_7");
        ldv(4'd12, 4'd12, 1'b0, "load_off_identity");
        adv(1'b0, 4'd3, 1'b0, "recover_identity");

        @(posedge clk);
        #1;
        en   = 1'b0;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_counter.md
SEQ_COUNTER -- requirements
Module: seq_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of count, load_val, table entries.
REQ-002 Parameter DEPTH, default 10: number of sequence-table entries, range 2..256.
REQ-003 Parameter RECOVER_IDX, default 3: table index entered on the first step after an off-table load, range 0..DEPTH-1.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  the block's one clock; all state changes on its falling edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance one step per falling edge.
- dir  in  1  0 = forward through the table, 1 = backward.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- wr_en  in  1  table write strobe.
- wr_addr  in  clog2(DEPTH)  table write index.
- wr_data  in  WIDTH  table write data.
- count  out  WIDTH  registered current sequence value.
- tc  out  1  registered one-cycle terminal-count pulse.
- on_table  out  1  1 when count came from the table.

Function
REQ-005 State is idx (clog2(DEPTH) bits), count, tc, on_table, and a DEPTH x WIDTH table.
REQ-006 There are two FSM states, ON_TABLE and OFF_TABLE; on_table is 1 exactly in ON_TABLE.
REQ-007 The priority at each falling edge is reset > load > en; with none active, count, idx and state hold, and tc = 0.
REQ-008 On load:
- The lowest index i with table[i] == load_val gives idx = i, count = load_val, state ON_TABLE.
- With no match: count = load_val, idx unchanged, state OFF_TABLE.
- In both cases tc = 0.
REQ-009 On en in ON_TABLE:
- dir=0: idx = (idx+1) mod DEPTH.
- dir=1: idx = (idx-1) mod DEPTH.
- count = table[new idx].
REQ-010 tc = 1 for exactly the cycle after a wrapping step: DEPTH-1 -> 0 with dir=0, or 0 -> DEPTH-1 with dir=1; otherwise tc = 0.
REQ-011 On en in OFF_TABLE: idx = RECOVER_IDX, count = table[RECOVER_IDX], state ON_TABLE, tc = 0, and dir is ignored.
REQ-012 A step uses table contents from before the same edge's write.
REQ-013 A write to the entry currently shown does not change count until that entry is next entered.
REQ-014 Writes with wr_addr >= DEPTH are ignored.
REQ-015 Table entries may be duplicated; stepping is by index, never by value.
REQ-016 Load matching (REQ-008) uses table contents from before the same edge's write.

Reset
REQ-017 While reset = 1, independent of clk: table[i] = i mod 2^WIDTH, idx = 0, count = 0, tc = 0, state ON_TABLE (on_table = 1).
REQ-018 Reset asserted mid-operation discards any pending load, step or write on that edge.
REQ-019 After reset release, the first falling edge with en = 1 and dir = 0 yields count = table[1].

Configuration
REQ-020 With macro SEQ_TABLE_WR_EN defined, wr_en, wr_addr and wr_data are functional per REQ-012..REQ-014.
REQ-021 Without SEQ_TABLE_WR_EN:
- the write ports remain present but are ignored;
- the table is constant at its reset contents;
- count equals idx zero-extended or truncated whenever state is ON_TABLE.

Verification (WIDTH=4, DEPTH=10, RECOVER_IDX=3, SEQ_TABLE_WR_EN defined)
REQ-022 Reset, then en=1, dir=0 for 10 edges -> count 1,2,...,9,0; tc = 1 only with the final 0.
REQ-023 Write table = 3,0,1,5,2,7,6,4,9,12, then load 6, then 4 en edges -> count 6, 4, 9, 12, 3; tc = 1 only with 3.
REQ-024 Programmed table as above, load 15 -> count = 15, on_table = 0; next en edge -> count = 5, on_table = 1, tc = 0.
REQ-025 After reset, en=1, dir=1, one edge -> count = 9, tc = 1; next edge -> count = 8, tc = 0.
REQ-026 Load 7 and en on the same edge -> count = 7, no step.
REQ-027 Step into idx 2 on the same edge as a write of 11 to wr_addr 2 -> count shows the old value; revisiting idx 2 shows 11.
REQ-028 Assert reset between edges mid-run -> count = 0 and tc = 0 immediately; the table reads as identity afterwards.
